vram_arbiter: RTL

- Shares one single-port tile RAM between two users: the display scan-out fetch and the game-logic writer.
- Display fetch has strict priority. Each fetch reads one tile row (COLS entries) into the renderer's line cache.
- Game writes are buffered in a small FIFO. They are committed to RAM only during vertical blanking (screen_start_i=1), so the board never tears mid-frame.
- Sits between the VGA sync generator, the tile renderer and the game FSM.

---
 rtl/vram_arbiter_if.sv | 49 ++++
 rtl/vram_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle for vram_arbiter: sync window, display fetch request/return,
// game write push side and the single-port tile RAM port.
//   slave  : arbiter view (drives fetch_*_o, wr_ready_o, pending_o, ram_*_o)
//   master : environment view (drives requests, write data and ram_rdata_i)
interface vram_arbiter_if #(
   parameter int unsigned COLS       = 20,
   parameter int unsigned ROW_W      = 4,
   parameter int unsigned ADDR_W     = 9,
   parameter int unsigned DATA_W     = 4,
   parameter int unsigned FIFO_DEPTH = 4
);
   localparam int unsigned COL_W = $clog2(COLS);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic              screen_start_i;
   logic              fetch_req_i;
   logic [ROW_W-1:0]  fetch_row_i;
   logic              fetch_busy_o;
   logic              fetch_valid_o;
   logic [COL_W-1:0]  fetch_col_o;
   logic [DATA_W-1:0] fetch_data_o;
   logic              fetch_overrun_o;
   logic              wr_valid_i;
   logic              wr_ready_o;
   logic [ADDR_W-1:0] wr_addr_i;
   logic [DATA_W-1:0] wr_data_i;
   logic [CNT_W-1:0]  pending_o;
   logic              ram_en_o;
   logic              ram_we_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic [DATA_W-1:0] ram_wdata_o;
   logic [DATA_W-1:0] ram_rdata_i;

   modport slave (
      input  screen_start_i, fetch_req_i, fetch_row_i, wr_valid_i, wr_addr_i,
             wr_data_i, ram_rdata_i,
      output fetch_busy_o, fetch_valid_o, fetch_col_o, fetch_data_o,
             fetch_overrun_o, wr_ready_o, pending_o, ram_en_o, ram_we_o,
             ram_addr_o, ram_wdata_o
   );

   modport master (
      output screen_start_i, fetch_req_i, fetch_row_i, wr_valid_i, wr_addr_i,
             wr_data_i, ram_rdata_i,
      input  fetch_busy_o, fetch_valid_o, fetch_col_o, fetch_data_o,
             fetch_overrun_o, wr_ready_o, pending_o, ram_en_o, ram_we_o,
             ram_addr_o, ram_wdata_o
   );
endinterface

// File: rtl/vram_arbiter.sv
// Tile RAM arbiter: display row fetch has strict priority; game writes are
// queued in a small FIFO and committed only during vertical blanking.
//   clk_i : pixel clock
//   rst_i : asynchronous active-high reset
//   bus   : vram_arbiter_if.slave (fetch, write FIFO and RAM port signals)
module vram_arbiter #(
   parameter int unsigned COLS       = 20,
   parameter int unsigned ROW_W      = 4,
   parameter int unsigned ADDR_W     = 9,
   parameter int unsigned DATA_W     = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   vram_arbiter_if.slave bus
);
   localparam int unsigned COL_W = $clog2(COLS);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [COL_W-1:0]  col_q, col_d;

   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              wr_ready_q;
   logic              push, pop, fifo_empty, accept;

   logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic [COL_W-1:0]  ram_col_q, ram_col_d;
   logic              busy_q, overrun_q;
   logic              rd_pend_q, valid_q;
   logic [COL_W-1:0]  rd_col_q, fcol_q;
   logic [DATA_W-1:0] fdata_q;

   assign push       = bus.wr_valid_i && wr_ready_q;
   assign fifo_empty = (count_q == '0);
   // busy covers the cycles whose read strobes are already committed
   assign accept     = bus.fetch_req_i && !busy_q && (state_q != FETCH);
   assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

   // Next-state and next RAM strobe; strobes are registered so they appear one cycle later
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      col_d       = col_q;
      pop         = 1'b0;
      ram_en_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = '0;
      ram_wdata_d = '0;
      ram_col_d   = '0;
      unique case (state_q)
         IDLE, DRAIN: begin
            if (accept) begin
               base_d     = ADDR_W'(32'(bus.fetch_row_i) * 32'(COLS));
               ram_en_d   = 1'b1;
               ram_addr_d = base_d;
               col_d      = COL_W'(1);
               state_d    = FETCH;
            end else if (state_q == IDLE) begin
               if (bus.screen_start_i && !fifo_empty) state_d = DRAIN;
            end else if (bus.screen_start_i && !fifo_empty) begin
               pop         = 1'b1;
               ram_en_d    = 1'b1;
               ram_we_d    = 1'b1;
               ram_addr_d  = fifo_addr[rd_ptr_q];
               ram_wdata_d = fifo_data[rd_ptr_q];
               // stay only if something is left after this pop
               state_d     = ((count_q != CNT_W'(1)) || push) ? DRAIN : IDLE;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            ram_en_d   = 1'b1;
            ram_addr_d = base_q + ADDR_W'(col_q);
            ram_col_d  = col_q;
            if (col_q == COL_W'(COLS - 1)) begin
               col_d   = '0;
               state_d = (bus.screen_start_i && !fifo_empty) ? DRAIN : IDLE;
            end else begin
               col_d = col_q + COL_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, FIFO control, RAM port and two-stage read return pipeline
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         base_q      <= '0;
         col_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         wr_ready_q  <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_col_q   <= '0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         rd_pend_q   <= 1'b0;
         rd_col_q    <= '0;
         valid_q     <= 1'b0;
         fcol_q      <= '0;
         fdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         col_q       <= col_d;
         count_q     <= count_d;
         wr_ready_q  <= (count_d < CNT_W'(FIFO_DEPTH));
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_col_q   <= ram_col_d;
         busy_q      <= ram_en_d && !ram_we_d;
         overrun_q   <= overrun_q || (bus.fetch_req_i && busy_q);
         rd_pend_q   <= ram_en_q && !ram_we_q;
         rd_col_q    <= ram_col_q;
         valid_q     <= rd_pend_q;
         fcol_q      <= rd_pend_q ? rd_col_q : '0;
         fdata_q     <= rd_pend_q ? bus.ram_rdata_i : '0;
      end
   end

   // FIFO storage needs no reset; occupancy gates every read of it
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_addr[wr_ptr_q] <= bus.wr_addr_i;
         fifo_data[wr_ptr_q] <= bus.wr_data_i;
      end
   end

   assign bus.fetch_busy_o    = busy_q;
   assign bus.fetch_valid_o   = valid_q;
   assign bus.fetch_col_o     = fcol_q;
   assign bus.fetch_data_o    = fdata_q;
   assign bus.fetch_overrun_o = overrun_q;
   assign bus.wr_ready_o      = wr_ready_q;
   assign bus.pending_o       = count_q;
   assign bus.ram_en_o        = ram_en_q;
   assign bus.ram_we_o        = ram_we_q;
   assign bus.ram_addr_o      = ram_addr_q;
   assign bus.ram_wdata_o     = ram_wdata_q;
endmodule
